// File: rtl/adpll_settle_meter.sv
// ADPLL lock-qualification and settling-time meter: measures en-to-lock latency,
// counts lock losses, flags acquisition timeouts. Define ADPLL_SETTLE_WORD_STATS_EN for tdc_word min/max.
module adpll_settle_meter #(
  parameter int CNT_W       = 24,
  parameter int WORD_W      = 12,
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int LOSS_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              channel_lock,
  input  logic [WORD_W-1:0] tdc_word,
  input  logic              clear,
  output logic              locked,
  output logic              settle_valid,
  output logic [CNT_W-1:0]  settle_cycles,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] lock_loss_count,
  output logic              timeout,
  output logic [WORD_W-1:0] word_min,
  output logic [WORD_W-1:0] word_max
);
  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_TGT = STAB_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0]  TMO_TGT  = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {S_IDLE, S_ACQUIRE, S_QUALIFY, S_LOCKED, S_TMO} state_t;

  state_t            state_q, state_d;
  logic              en_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  lock_start_q, lock_start_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic [STAB_W-1:0] stab_q, stab_d, stab_inc;
  logic              valid_q, valid_d, lost_q, lost_d, tmo_q, tmo_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              rise, enter_lock, stay_lock;

  assign rise     = en & ~en_q;
  // cnt_inc is the value cnt holds after this edge, so a lock sampled at edge L reports L-E
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign stab_inc = stab_q + STAB_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_start_d = lock_start_q;
    stab_d       = stab_q;
    settle_d     = settle_q;
    valid_d      = valid_q;
    lost_d       = 1'b0;
    loss_d       = loss_q;
    tmo_d        = tmo_q;
    if (clear) begin
      loss_d   = '0;
      tmo_d    = 1'b0;
      valid_d  = 1'b0;
      settle_d = '0;
      cnt_d    = '0;
      stab_d   = '0;
      state_d  = en ? S_ACQUIRE : S_IDLE;
    end else if (state_q != S_IDLE && !en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (rise) begin
          state_d = S_ACQUIRE;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
        S_ACQUIRE: begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO_TGT) begin
            state_d = S_TMO;
            tmo_d   = 1'b1;
          end else if (channel_lock) begin
            lock_start_d = cnt_inc;
            stab_d       = STAB_W'(1);
            if (STABLE_CYC == 1) begin
              state_d  = S_LOCKED;
              settle_d = cnt_inc;
              valid_d  = 1'b1;
            end else begin
              state_d = S_QUALIFY;
            end
          end
        end
        S_QUALIFY: begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO_TGT) begin
            state_d = S_TMO;
            tmo_d   = 1'b1;
          end else if (!channel_lock) begin
            state_d = S_ACQUIRE;
          end else begin
            stab_d = stab_inc;
            if (stab_inc == STAB_TGT) begin
              state_d  = S_LOCKED;
              settle_d = lock_start_q;
              valid_d  = 1'b1;
            end
          end
        end
        S_LOCKED: if (!channel_lock) begin
          lost_d  = 1'b1;
          loss_d  = (&loss_q) ? loss_q : loss_q + LOSS_W'(1);
          state_d = S_ACQUIRE;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      en_q         <= 1'b0;
      cnt_q        <= '0;
      lock_start_q <= '0;
      stab_q       <= '0;
      settle_q     <= '0;
      valid_q      <= 1'b0;
      lost_q       <= 1'b0;
      loss_q       <= '0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en;
      cnt_q        <= cnt_d;
      lock_start_q <= lock_start_d;
      stab_q       <= stab_d;
      settle_q     <= settle_d;
      valid_q      <= valid_d;
      lost_q       <= lost_d;
      loss_q       <= loss_d;
      tmo_q        <= tmo_d;
    end
  end

  assign enter_lock = (state_d == S_LOCKED) && (state_q != S_LOCKED);
  assign stay_lock  = (state_d == S_LOCKED) && (state_q == S_LOCKED);

  assign locked          = (state_q == S_LOCKED);
  assign settle_valid    = valid_q;
  assign settle_cycles   = settle_q;
  assign lock_lost       = lost_q;
  assign lock_loss_count = loss_q;
  assign timeout         = tmo_q;

`ifdef ADPLL_SETTLE_WORD_STATS_EN
  logic [WORD_W-1:0] wmin_q, wmax_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wmin_q <= '0;
      wmax_q <= '0;
    end else if (clear) begin
      wmin_q <= '1;
      wmax_q <= '0;
    end else if (enter_lock) begin
      wmin_q <= tdc_word;
      wmax_q <= tdc_word;
    end else if (stay_lock) begin
      if (tdc_word < wmin_q) wmin_q <= tdc_word;
      if (tdc_word > wmax_q) wmax_q <= tdc_word;
    end
  end

  assign word_min = wmin_q;
  assign word_max = wmax_q;
`else
  logic unused_word_stats;
  assign unused_word_stats = ^{tdc_word, enter_lock, stay_lock};
  assign word_min = '0;
  assign word_max = '0;
`endif
endmodule

// File: tb/tb_adpll_settle_meter.sv
// Randomized scenario bench for adpll_settle_meter; expectations come from edge arithmetic
// (settle = lock edge - en edge, lock after S samples) and min/max over recorded words.
module tb_adpll_settle_meter;
  localparam int CNT_W = 24, WORD_W = 12, S = 16, T = 500, LOSS_W = 2, MAXE = 1024;
`ifdef ADPLL_SETTLE_WORD_STATS_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, channel_lock, clear;
  logic [WORD_W-1:0] tdc_word;
  logic locked, settle_valid, lock_lost, timeout;
  logic [CNT_W-1:0]  settle_cycles;
  logic [LOSS_W-1:0] lock_loss_count;
  logic [WORD_W-1:0] word_min, word_max;

  int checks = 0, failures = 0;

  logic              locked_tr [MAXE];
  logic              lost_tr   [MAXE];
  logic              valid_tr  [MAXE];
  logic              tmo_tr    [MAXE];
  logic [CNT_W-1:0]  settle_tr [MAXE];
  logic [WORD_W-1:0] tdc_tr    [MAXE];

  adpll_settle_meter #(.CNT_W(CNT_W), .WORD_W(WORD_W), .STABLE_CYC(S),
                       .TIMEOUT_CYC(T), .LOSS_W(LOSS_W)) dut (
    .clk(clk), .rst(rst), .en(en), .channel_lock(channel_lock), .tdc_word(tdc_word),
    .clear(clear), .locked(locked), .settle_valid(settle_valid),
    .settle_cycles(settle_cycles), .lock_lost(lock_lost),
    .lock_loss_count(lock_loss_count), .timeout(timeout),
    .word_min(word_min), .word_max(word_max));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Edge 0 samples en=1; lock is high on edges [on, off) and from back onward.
  task automatic run_seq(input bit do_clear, input int n, input int on, input int off, input int back);
    en = 1'b0; channel_lock = 1'b0; clear = do_clear; tick(); clear = 1'b0;
    en = 1'b1; tick();
    for (int e = 1; e <= n; e++) begin
      channel_lock = (e >= on) && !(e >= off && e < back);
      tdc_word = WORD_W'($urandom);
      tdc_tr[e] = tdc_word;
      tick();
      locked_tr[e] = locked; lost_tr[e] = lock_lost; valid_tr[e] = settle_valid;
      tmo_tr[e] = timeout;   settle_tr[e] = settle_cycles;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; channel_lock = 1'b0; clear = 1'b0; tdc_word = '0;
    tick(); tick();
    checks++;
    if ({locked, settle_valid, settle_cycles, lock_lost, lock_loss_count, timeout, word_min, word_max} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%0h exp=0",
        {locked, settle_valid, settle_cycles, lock_lost, lock_loss_count, timeout, word_min, word_max});
    end
    #2 rst = 1'b0;
    tick();
    checks++;
    if (locked !== 1'b0 || settle_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release locked=%0b valid=%0b exp=0/0", locked, settle_valid);
    end
  endtask

  task automatic test_basic();
    for (int it = 0; it < 3; it++) begin
      int L, n, emin, emax;
      L = (it == 0) ? 100 : int'($urandom_range(2, 300));
      n = L + S + 4;
      run_seq(1'b1, n, L, MAXE, MAXE);
      checks++; if (locked_tr[L+S-2] !== 1'b0) begin failures++; $display("FAIL basic_early_lock L=%0d got=%0b exp=0", L, locked_tr[L+S-2]); end
      checks++; if (locked_tr[L+S-1] !== 1'b1) begin failures++; $display("FAIL basic_lock_edge L=%0d got=%0b exp=1", L, locked_tr[L+S-1]); end
      checks++; if (valid_tr[L+S-2] !== 1'b0) begin failures++; $display("FAIL basic_early_valid L=%0d got=%0b exp=0", L, valid_tr[L+S-2]); end
      checks++; if (settle_tr[n] !== CNT_W'(L)) begin failures++; $display("FAIL basic_settle got=%0d exp=%0d", settle_tr[n], L); end
      checks++; if (valid_tr[n] !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", valid_tr[n]); end
      emin = 4095; emax = 0;
      for (int e = L + S - 1; e <= n; e++) begin
        if (int'(tdc_tr[e]) < emin) emin = int'(tdc_tr[e]);
        if (int'(tdc_tr[e]) > emax) emax = int'(tdc_tr[e]);
      end
      if (!FEAT) begin emin = 0; emax = 0; end
      checks++; if (word_min !== WORD_W'(emin) || word_max !== WORD_W'(emax)) begin
        failures++; $display("FAIL basic_words got=%0d/%0d exp=%0d/%0d", word_min, word_max, emin, emax);
      end
    end
  endtask

  task automatic test_glitch();
    for (int it = 0; it < 2; it++) begin
      int g0, glen, L2, n, pulses;
      if (it == 0) begin g0 = 50; glen = 6; L2 = 200; end
      else begin
        g0 = $urandom_range(5, 60); glen = $urandom_range(1, S - 1);
        L2 = $urandom_range(g0 + glen + 1, 250);
      end
      n = L2 + S + 2;
      run_seq(1'b1, n, g0, g0 + glen, L2);
      pulses = 0;
      for (int e = 1; e <= n; e++) pulses += int'(lost_tr[e]);
      checks++; if (locked_tr[g0+glen-1] !== 1'b0) begin failures++; $display("FAIL glitch_no_lock got=%0b exp=0", locked_tr[g0+glen-1]); end
      checks++; if (settle_tr[n] !== CNT_W'(L2) || valid_tr[n] !== 1'b1) begin
        failures++; $display("FAIL glitch_settle got=%0d/%0b exp=%0d/1", settle_tr[n], valid_tr[n], L2);
      end
      checks++; if (pulses != 0 || lock_loss_count !== '0) begin
        failures++; $display("FAIL glitch_no_loss pulses=%0d count=%0d exp=0/0", pulses, lock_loss_count);
      end
    end
  endtask

  task automatic test_loss();
    for (int it = 0; it < 2; it++) begin
      int L, D, k, R, n, pulses;
      L = $urandom_range(2, 80);
      D = L + S - 1 + int'($urandom_range(1, 20));
      k = (it == 0) ? 3 : int'($urandom_range(1, 5));
      R = D + k; n = R + S + 2;
      run_seq(1'b1, n, L, D, R);
      pulses = 0;
      for (int e = 1; e <= n; e++) pulses += int'(lost_tr[e]);
      checks++; if (lost_tr[D] !== 1'b1 || pulses != 1) begin
        failures++; $display("FAIL loss_pulse at_drop=%0b pulses=%0d exp=1/1", lost_tr[D], pulses);
      end
      checks++; if (lock_loss_count !== LOSS_W'(1)) begin failures++; $display("FAIL loss_count got=%0d exp=1", lock_loss_count); end
      checks++; if (valid_tr[D] !== 1'b0 || locked_tr[D] !== 1'b0) begin
        failures++; $display("FAIL loss_flags valid=%0b locked=%0b exp=0/0", valid_tr[D], locked_tr[D]);
      end
      checks++; if (settle_tr[D] !== CNT_W'(L)) begin failures++; $display("FAIL loss_retain got=%0d exp=%0d", settle_tr[D], L); end
      checks++; if (locked_tr[R+S-2] !== 1'b0 || locked_tr[R+S-1] !== 1'b1) begin
        failures++; $display("FAIL loss_requal got=%0b%0b exp=01", locked_tr[R+S-2], locked_tr[R+S-1]);
      end
      checks++; if (settle_tr[n] !== CNT_W'(k) || valid_tr[n] !== 1'b1) begin
        failures++; $display("FAIL loss_resettle got=%0d/%0b exp=%0d/1", settle_tr[n], valid_tr[n], k);
      end
    end
  endtask

  task automatic test_loss_sat();
    run_seq(1'b1, 5 + S + 1, 5, MAXE, MAXE);
    for (int k = 1; k <= 5; k++) begin
      int exp_cnt;
      exp_cnt = (k < 3) ? k : 3;
      channel_lock = 1'b0; tick();
      checks++; if (lock_lost !== 1'b1 || lock_loss_count !== LOSS_W'(exp_cnt)) begin
        failures++; $display("FAIL sat_count k=%0d got=%0b/%0d exp=1/%0d", k, lock_lost, lock_loss_count, exp_cnt);
      end
      channel_lock = 1'b1; tick();
      checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL sat_pulse_width k=%0d got=%0b exp=0", k, lock_lost); end
      repeat (S - 1) tick();
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sat_relock k=%0d got=%0b exp=1", k, locked); end
    end
  endtask

  task automatic test_timeout();
    int late, n;
    late = $urandom_range(505, 600); n = 620;
    run_seq(1'b1, n, late, MAXE, MAXE);
    checks++; if (tmo_tr[T-1] !== 1'b0) begin failures++; $display("FAIL tmo_early got=%0b exp=0", tmo_tr[T-1]); end
    checks++; if (tmo_tr[T] !== 1'b1) begin failures++; $display("FAIL tmo_edge got=%0b exp=1", tmo_tr[T]); end
    checks++; if (locked_tr[n] !== 1'b0 || valid_tr[n] !== 1'b0 || tmo_tr[n] !== 1'b1) begin
      failures++; $display("FAIL tmo_ignore_lock locked=%0b valid=%0b tmo=%0b exp=0/0/1", locked_tr[n], valid_tr[n], tmo_tr[n]);
    end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (timeout !== 1'b0 || locked !== 1'b0) begin
      failures++; $display("FAIL tmo_clear tmo=%0b locked=%0b exp=0/0", timeout, locked);
    end
    repeat (S - 1) tick();
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL tmo_acq_early got=%0b exp=0", locked); end
    tick();
    checks++; if (locked !== 1'b1 || settle_cycles !== CNT_W'(1)) begin
      failures++; $display("FAIL tmo_acq_lock got=%0b/%0d exp=1/1", locked, settle_cycles);
    end
  endtask

  task automatic test_simultaneous();
    int L, L2;
    L = $urandom_range(2, 100);
    run_seq(1'b1, L + S + 3, L, MAXE, MAXE);
    en = 1'b0; channel_lock = 1'b0; tick();
    checks++; if (locked !== 1'b0 || lock_lost !== 1'b0 || lock_loss_count !== '0) begin
      failures++; $display("FAIL simul_flags locked=%0b lost=%0b count=%0d exp=0/0/0", locked, lock_lost, lock_loss_count);
    end
    checks++; if (settle_cycles !== CNT_W'(L) || settle_valid !== 1'b1) begin
      failures++; $display("FAIL simul_retain got=%0d/%0b exp=%0d/1", settle_cycles, settle_valid, L);
    end
    L2 = $urandom_range(2, 50);
    run_seq(1'b0, L2 + 4, L2, MAXE, MAXE);
    checks++; if (settle_cycles !== CNT_W'(L) || settle_valid !== 1'b0 || locked !== 1'b0) begin
      failures++; $display("FAIL qualify_state got=%0d/%0b/%0b exp=%0d/0/0", settle_cycles, settle_valid, locked, L);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({locked, settle_valid, settle_cycles, lock_lost, lock_loss_count, timeout, word_min, word_max} !== '0) begin
      failures++; $display("FAIL async_rst got=%0h exp=0",
        {locked, settle_valid, settle_cycles, lock_lost, lock_loss_count, timeout, word_min, word_max});
    end
    #3 rst = 1'b0;
  endtask

  task automatic test_word_stats();
    int L;
    L = $urandom_range(2, 40);
    run_seq(1'b1, L + S - 2, L, MAXE, MAXE);
    channel_lock = 1'b1;
    tdc_word = 12'd40; tick();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL words_entry got=%0b exp=1", locked); end
    tdc_word = 12'd37; tick();
    tdc_word = 12'd45; tick();
    tdc_word = 12'd41; tick();
    checks++; if (word_min !== (FEAT ? 12'd37 : 12'd0) || word_max !== (FEAT ? 12'd45 : 12'd0)) begin
      failures++; $display("FAIL words_track got=%0d/%0d exp=%0d/%0d", word_min, word_max, FEAT ? 37 : 0, FEAT ? 45 : 0);
    end
    channel_lock = 1'b0; tick();
    tdc_word = 12'd0; tick();
    tdc_word = '1; tick();
    checks++; if (word_min !== (FEAT ? 12'd37 : 12'd0) || word_max !== (FEAT ? 12'd45 : 12'd0)) begin
      failures++; $display("FAIL words_hold got=%0d/%0d exp=%0d/%0d", word_min, word_max, FEAT ? 37 : 0, FEAT ? 45 : 0);
    end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (word_min !== (FEAT ? 12'hfff : 12'd0) || word_max !== 12'd0) begin
      failures++; $display("FAIL words_clear got=%0d/%0d exp=%0d/0", word_min, word_max, FEAT ? 4095 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_loss();
    test_loss_sat();
    test_timeout();
    test_simultaneous();
    test_word_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
